// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit.
// MULT/MULTU/DIV/DIVU take 32 busy cycles. Each one works on operand
// magnitudes, and the sign is fixed up on the final edge.
// MTHI/MTLO write HI/LO directly on the accept edge.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_a;        // multiplicand magnitude (MUL)
  logic [WIDTH-1:0]     r_b;        // multiplier / divisor magnitude
  logic [2*WIDTH-1:0]   r_acc;      // product, or {remainder, dividend/quotient}
  logic [WIDTH-1:0]     r_a_raw;    // SrcA as captured, returned on divide by zero
  logic                 r_neg_q;    // negate product / quotient at the end
  logic                 r_neg_r;    // negate remainder at the end
  logic                 r_divz;     // divisor was zero
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_div_top;
  logic [WIDTH-1:0]     w_div_sub;
  logic                 w_div_ge;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Operand magnitudes. op[0]=0 selects the signed MULT/DIV variants.
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & SrcA[WIDTH-1];
  assign w_b_neg  = w_signed & SrcB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -SrcA : SrcA;
  assign w_b_mag  = w_b_neg ? -SrcB : SrcB;
  assign w_last   = busy && (r_cnt == LAST);

  // One iteration step for both multiply (shift-add) and divide (restoring).
  always_comb begin
    w_mul_acc = r_acc;
    if (r_b[r_cnt]) begin
      w_mul_acc = r_acc + ({{WIDTH{1'b0}}, r_a} << r_cnt);
    end else begin
      w_mul_acc = r_acc;
    end
    w_div_top = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_ge  = (w_div_top >= {1'b0, r_b});
    w_div_sub = w_div_top[WIDTH-1:0] - r_b;
    if (w_div_ge) begin
      w_div_acc = {w_div_sub, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_acc = {r_acc[2*WIDTH-2:0], 1'b0};
    end
    if (r_state == S_MUL) begin
      w_step = w_mul_acc;
    end else begin
      w_step = w_div_acc;
    end
  end

  // Final result with sign correction and the divide-by-zero override.
  always_comb begin
    w_prod   = r_neg_q ? -w_step : w_step;
    w_quo    = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
    w_rem    = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_state == S_DIV) begin
      if (r_divz) begin
        w_res_hi = r_a_raw;
        w_res_lo = {WIDTH{1'b1}};
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // FSM next state: leave IDLE only on an accepted mult/div, return after the last step.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: w_next = S_MUL;
            OP_DIV,  OP_DIVU:  w_next = S_DIV;
            default:           w_next = S_IDLE;
          endcase
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (r_cnt == LAST) begin
          w_next = S_IDLE;
        end else begin
          w_next = r_state;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM state register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath: operand capture, iteration, HI/LO update and done pulse.
  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_a_raw <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_divz  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              r_cnt   <= '0;
              r_a     <= w_a_mag;
              r_b     <= w_b_mag;
              r_a_raw <= SrcA;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_divz  <= (SrcB == {WIDTH{1'b0}});
              if (op[1]) begin
                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
              end else begin
                r_acc <= '0;
              end
            end
            OP_MTHI: r_hi <= SrcA;
            OP_MTLO: r_lo <= SrcA;
            default: ;
          endcase
        end
      end else begin
        r_acc <= w_step;
        if (w_last) begin
          r_cnt  <= '0;
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO results.
module tb_mult_div_unit;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .rst(rst), .start(start), .op(op),
    .SrcA(SrcA), .SrcB(SrcB), .HI(HI), .LO(LO),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Issue one mult/div, count busy cycles, check the done pulse and HI/LO.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e,
                        input logic [31:0] lo_e, input bit inject);
    int n;
    @(negedge CLK);
    start = 1'b1; op = o; SrcA = a; SrcB = b;
    @(negedge CLK);
    start = 1'b0; SrcA = ~a; SrcB = ~b; op = 3'b110;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (inject && n == 5) begin
        start = 1'b1; op = 3'b001; SrcA = 32'd2; SrcB = 32'd3;
      end
      if (inject && n == 6) begin
        start = 1'b0; op = 3'b110;
      end
      if (n == 16) begin
        check_eq({tag, "_hold_hi"}, {32'h0, HI}, {32'h0, exp_hi});
        check_eq({tag, "_hold_lo"}, {32'h0, LO}, {32'h0, exp_lo});
      end
      n++;
      @(negedge CLK);
    end
    check_eq({tag, "_busy_cycles"}, 64'(n), 64'd32);
    check_eq({tag, "_done_pulse"}, {63'h0, done}, 64'd1);
    check_eq({tag, "_hi"}, {32'h0, HI}, {32'h0, hi_e});
    check_eq({tag, "_lo"}, {32'h0, LO}, {32'h0, lo_e});
    exp_hi = hi_e;
    exp_lo = lo_e;
    @(negedge CLK);
    check_eq({tag, "_done_clear"}, {63'h0, done}, 64'd0);
    check_eq({tag, "_busy_after"}, {63'h0, busy}, 64'd0);
  endtask

  initial begin : stim
    int  n;
    bit  saw_done;
    rst = 1'b0; start = 1'b1; op = 3'b100; SrcA = 32'hDEADBEEF; SrcB = 32'h0;

    // Reset with start held high: nothing may be accepted.
    repeat (3) @(negedge CLK);
    check_eq("rst_hi",   {32'h0, HI}, 64'h0);
    check_eq("rst_lo",   {32'h0, LO}, 64'h0);
    check_eq("rst_busy", {63'h0, busy}, 64'd0);
    check_eq("rst_done", {63'h0, done}, 64'd0);
    rst = 1'b1; start = 1'b0; op = 3'b110;

    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult_neg",  3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_zero", 3'b011, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    run_op("div_zero",  3'b010, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);

    // MTHI then MTLO on consecutive edges.
    @(negedge CLK);
    start = 1'b1; op = 3'b100; SrcA = 32'h12345678;
    @(negedge CLK);
    check_eq("mthi_hi",   {32'h0, HI}, 64'h12345678);
    check_eq("mthi_busy", {63'h0, busy}, 64'd0);
    check_eq("mthi_done", {63'h0, done}, 64'd0);
    op = 3'b101; SrcA = 32'h9ABCDEF0;
    @(negedge CLK);
    start = 1'b0;
    check_eq("mtlo_lo",   {32'h0, LO}, 64'h9ABCDEF0);
    check_eq("mtlo_hi",   {32'h0, HI}, 64'h12345678);
    check_eq("mtlo_busy", {63'h0, busy}, 64'd0);
    check_eq("mtlo_done", {63'h0, done}, 64'd0);
    exp_hi = 32'h12345678;
    exp_lo = 32'h9ABCDEF0;

    // No-op opcodes change nothing.
    start = 1'b1; op = 3'b110; SrcA = 32'h11111111;
    @(negedge CLK);
    op = 3'b111;
    @(negedge CLK);
    start = 1'b0;
    check_eq("nop_hi",   {32'h0, HI}, {32'h0, exp_hi});
    check_eq("nop_lo",   {32'h0, LO}, {32'h0, exp_lo});
    check_eq("nop_busy", {63'h0, busy}, 64'd0);

    // Abort MULTU 3x4 with reset at busy cycle 10.
    start = 1'b1; op = 3'b001; SrcA = 32'd3; SrcB = 32'd4;
    @(negedge CLK);
    start = 1'b0;
    check_eq("abort_busy_start", {63'h0, busy}, 64'd1);
    repeat (9) @(negedge CLK);
    rst = 1'b0;
    @(negedge CLK);
    check_eq("abort_busy", {63'h0, busy}, 64'd0);
    check_eq("abort_hi",   {32'h0, HI}, 64'h0);
    check_eq("abort_lo",   {32'h0, LO}, 64'h0);
    check_eq("abort_done", {63'h0, done}, 64'd0);
    rst = 1'b1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;
    saw_done = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    check_eq("abort_no_done", {63'h0, saw_done}, 64'd0);
    run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
